// File: rtl/rom_uart_dumper.sv
// rom_uart_dumper
// Reads WORDS consecutive 32-bit words from the instruction ROM, starting at
// word index 0. Each word is sent as four 8N1 UART bytes, least-significant
// byte first. The host uses this to read back and verify a program image
// written by the UART loader. The block runs in the clkIn domain.
//
// Ports:
//   clk      system clock (clkIn domain)
//   rst_n    asynchronous active-low reset; aborts any dump in progress
//   start    single-cycle dump request, accepted only in IDLE
//   rom_addr ROM word index, zero-extended from the 16-bit word counter
//   rom_data ROM word at rom_addr (combinational read, same cycle)
//   uart_tx  serial output, idles high
//   busy     high while a dump is in progress
//   done     one-cycle pulse after the final stop bit of the final word
module rom_uart_dumper #(
  parameter int CLK_DIV = 16,
  parameter int WORDS   = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  output logic        uart_tx,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    STOP
  } state_t;

  localparam logic [15:0] BAUD_RELOAD = 16'(CLK_DIV - 1);
  localparam logic [15:0] LAST_WORD   = 16'(WORDS - 1);

  state_t      state;
  logic [15:0] baud_cnt;
  logic [15:0] word_cnt;
  logic [2:0]  bit_cnt;
  logic [1:0]  byte_cnt;
  logic [31:0] shift_reg;
  logic        bit_end;

  // Every bit (start, data, stop) ends on the cycle the baud counter hits 0.
  assign bit_end  = (baud_cnt == 16'd0);
  assign rom_addr = {16'b0, word_cnt};

  // Control FSM. uart_tx is registered and is updated on the same edge as
  // the state change, so the line value always matches the current state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= 16'd0;
      word_cnt <= 16'd0;
      bit_cnt  <= 3'd0;
      byte_cnt <= 2'd0;
      uart_tx  <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          uart_tx <= 1'b1;
          busy    <= 1'b0;
          // A start that coincides with the done pulse belongs to the dump
          // that just finished, so it is dropped.
          if (start && !done) begin
            state    <= LOAD;
            word_cnt <= 16'd0;
            busy     <= 1'b1;
          end
        end
        LOAD: begin
          state    <= START;
          byte_cnt <= 2'd0;
          baud_cnt <= BAUD_RELOAD;
          uart_tx  <= 1'b0;
        end
        START: begin
          if (bit_end) begin
            state    <= DATA;
            bit_cnt  <= 3'd0;
            baud_cnt <= BAUD_RELOAD;
            uart_tx  <= shift_reg[0];
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= BAUD_RELOAD;
            if (bit_cnt == 3'd7) begin
              state   <= STOP;
              uart_tx <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              // shift_reg shifts on this same edge, so bit 1 is the next bit.
              uart_tx <= shift_reg[1];
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (byte_cnt != 2'd3) begin
              byte_cnt <= byte_cnt + 2'd1;
              state    <= START;
              baud_cnt <= BAUD_RELOAD;
              uart_tx  <= 1'b0;
            end else if (word_cnt != LAST_WORD) begin
              word_cnt <= word_cnt + 16'd1;
              state    <= LOAD;
            end else begin
              state <= IDLE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        default: begin
          state   <= IDLE;
          uart_tx <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // Word shift register (datapath, no reset). It is loaded only in LOAD,
  // so rom_data changes at any other time cannot reach the line. After 8
  // shifts the next byte of the word sits in bits [7:0].
  always_ff @(posedge clk) begin
    if (state == LOAD) begin
      shift_reg <= rom_data;
    end else if (state == DATA && bit_end) begin
      shift_reg <= {1'b0, shift_reg[31:1]};
    end
  end

endmodule

// File: tb/tb_rom_uart_dumper.sv
// Bench for rom_uart_dumper. Two instances are used:
//   u_a: CLK_DIV=4,  WORDS=3
//   u_b: CLK_DIV=16, WORDS=1
// Each vector row gives the ROM image and the byte stream expected on
// uart_tx, in transmission order. The line is sampled on falling edges.
module tb_rom_uart_dumper;

  localparam int CD_A = 4;
  localparam int CD_B = 16;

  typedef struct packed {
    logic [95:0] words;   // word0 in [95:64], word1 in [63:32], word2 in [31:0]
    logic [95:0] exp;     // first byte sent in [95:88]
    logic [1:0]  nw;
    logic        sel;     // 0: u_a, 1: u_b
    logic        perturb; // scramble rom_data outside LOAD cycles
    logic        poke;    // pulse start mid-byte and in the done cycle
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_req = 1'b0;
  logic        sel = 1'b0;
  logic [31:0] noise = 32'd0;
  logic [31:0] rom_mem [3];

  logic        start_a, start_b;
  logic [31:0] addr_a, addr_b, data_a, data_b;
  logic        tx_a, tx_b, busy_a, busy_b, done_a, done_b;
  logic        cur_tx, cur_busy, cur_done;
  logic [31:0] cur_addr;

  int total = 0;
  int bad = 0;
  vec_t vecs [5];

  always #5 clk = ~clk;

  assign start_a  = start_req & ~sel;
  assign start_b  = start_req & sel;
  assign cur_tx   = sel ? tx_b   : tx_a;
  assign cur_busy = sel ? busy_b : busy_a;
  assign cur_done = sel ? done_b : done_a;
  assign cur_addr = sel ? addr_b : addr_a;

  always_comb begin
    data_a = 32'hBAD0_0BAD;
    if (addr_a < 32'd3) data_a = rom_mem[addr_a[1:0]];
    data_a = data_a ^ noise;
    data_b = ((addr_b == 32'd0) ? rom_mem[0] : 32'hBAD0_0BAD) ^ noise;
  end

  rom_uart_dumper #(.CLK_DIV(CD_A), .WORDS(3)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .rom_addr(addr_a),
    .rom_data(data_a), .uart_tx(tx_a), .busy(busy_a), .done(done_a)
  );

  rom_uart_dumper #(.CLK_DIV(CD_B), .WORDS(1)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .rom_addr(addr_b),
    .rom_data(data_b), .uart_tx(tx_b), .busy(busy_b), .done(done_b)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Runs one dump cycle-by-cycle. Any timing error shifts the bit
  // boundaries and shows up as a wrong byte, framing bit or glitch.
  task automatic run_vec(input int idx, input vec_t v);
    int         cd;
    int         nw;
    int         k;
    int         errs;
    logic       bitv;
    logic [7:0] byt;
    cd   = v.sel ? CD_B : CD_A;
    nw   = int'(v.nw);
    errs = 0;
    bitv = 1'b1;
    byt  = 8'h00;
    sel  = v.sel;
    noise = 32'd0;
    for (int w = 0; w < 3; w++) rom_mem[w] = v.words[95-32*w -: 32];
    @(negedge clk);
    check($sformatf("v%0d_idle_busy", idx), {31'd0, cur_busy}, 32'd0);
    start_req = 1'b1;
    for (int w = 0; w < nw; w++) begin
      @(negedge clk);
      start_req = 1'b0;
      noise = 32'd0;
      check($sformatf("v%0d_w%0d_load_tx", idx, w), {31'd0, cur_tx}, 32'd1);
      check($sformatf("v%0d_w%0d_addr", idx, w), cur_addr, w);
      for (int by = 0; by < 4; by++) begin
        for (int b = 0; b < 10; b++) begin
          for (int c = 0; c < cd; c++) begin
            @(negedge clk);
            if (c == 0) bitv = cur_tx;
            else if (cur_tx !== bitv) errs++;
            if (cur_busy !== 1'b1 || cur_done !== 1'b0) errs++;
            start_req = v.poke && w == 0 && by == 1 && b == 3 && c == 1;
            noise = v.perturb ? $urandom : 32'd0;
          end
          if (b == 0) check($sformatf("v%0d_w%0d_b%0d_startbit", idx, w, by), {31'd0, bitv}, 32'd0);
          else if (b == 9) check($sformatf("v%0d_w%0d_b%0d_stopbit", idx, w, by), {31'd0, bitv}, 32'd1);
          else byt[b-1] = bitv;
        end
        k = 4 * w + by;
        check($sformatf("v%0d_byte%0d", idx, k), {24'd0, byt}, {24'd0, v.exp[95-8*k -: 8]});
      end
    end
    check($sformatf("v%0d_glitch_or_ctrl", idx), errs, 32'd0);
    @(negedge clk);
    noise = 32'd0;
    check($sformatf("v%0d_done_pulse", idx), {31'd0, cur_done}, 32'd1);
    check($sformatf("v%0d_done_busy", idx), {31'd0, cur_busy}, 32'd0);
    check($sformatf("v%0d_done_tx", idx), {31'd0, cur_tx}, 32'd1);
    check($sformatf("v%0d_addr_hold", idx), cur_addr, nw - 1);
    start_req = v.poke;   // start in the done cycle must be ignored
    @(negedge clk);
    start_req = 1'b0;
    check($sformatf("v%0d_done_clear", idx), {31'd0, cur_done}, 32'd0);
    check($sformatf("v%0d_after_busy", idx), {31'd0, cur_busy}, 32'd0);
    @(negedge clk);
    check($sformatf("v%0d_after_busy2", idx), {31'd0, cur_busy}, 32'd0);
    check($sformatf("v%0d_after_tx", idx), {31'd0, cur_tx}, 32'd1);
  endtask

  initial begin
    vecs[0] = '{words: 96'hDEADBEEF_00000000_FFFFFFFF, exp: 96'hEFBEADDE_00000000_FFFFFFFF,
                nw: 2'd3, sel: 1'b0, perturb: 1'b0, poke: 1'b0};
    vecs[1] = '{words: 96'h12345678_00000000_00000000, exp: 96'h78563412_00000000_00000000,
                nw: 2'd1, sel: 1'b1, perturb: 1'b0, poke: 1'b1};
    vecs[2] = '{words: 96'h12345678_A5A5A5A5_00000001, exp: 96'h78563412_A5A5A5A5_01000000,
                nw: 2'd3, sel: 1'b0, perturb: 1'b1, poke: 1'b0};
    vecs[3] = '{words: 96'h0F0F0F0F_80000001_55AA33CC, exp: 96'h0F0F0F0F_01000080_CC33AA55,
                nw: 2'd3, sel: 1'b0, perturb: 1'b1, poke: 1'b1};
    vecs[4] = '{words: 96'hFFFFFFFF_00000000_00000000, exp: 96'hFFFFFFFF_00000000_00000000,
                nw: 2'd1, sel: 1'b1, perturb: 1'b1, poke: 1'b0};
    for (int w = 0; w < 3; w++) rom_mem[w] = 32'd0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx_a", {31'd0, tx_a}, 32'd1);
    check("rst_busy_a", {31'd0, busy_a}, 32'd0);
    check("rst_done_a", {31'd0, done_a}, 32'd0);
    check("rst_addr_a", addr_a, 32'd0);
    check("rst_tx_b", {31'd0, tx_b}, 32'd1);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

    // Async reset in the middle of word 1's DATA phase
    sel = 1'b0;
    for (int w = 0; w < 3; w++) rom_mem[w] = vecs[0].words[95-32*w -: 32];
    @(negedge clk);
    start_req = 1'b1;
    @(negedge clk);
    start_req = 1'b0;
    repeat (171) @(negedge clk);
    check("mid_addr", addr_a, 32'd1);
    check("mid_tx_low", {31'd0, tx_a}, 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_tx", {31'd0, tx_a}, 32'd1);
    check("arst_busy", {31'd0, busy_a}, 32'd0);
    check("arst_addr", addr_a, 32'd0);
    @(negedge clk);
    check("arst_done", {31'd0, done_a}, 32'd0);
    rst_n = 1'b1;
    run_vec(5, vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
